// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter
// Two-master round-robin request arbiter in front of the DDR controller.
// It turns valid/ready requests into single-cycle write_req/read_req pulses,
// spaced at least three cycles apart, and keeps an in-order tag FIFO so each
// rd_valid return is routed back to the master that issued the read.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mX_valid/we/addr/bank/wdata  master X request (X = 0, 1)
//   mX_ready                 request accepted this cycle (combinational)
//   mX_rvalid/rdata          routed read return (registered, one-cycle pulse)
//   write_req, read_req      one-cycle pulses to the controller
//   addr_out/bank_out/wdata_out  captured request fields, held until next grant
//   ctrl_ready               controller wr_ready
//   rd_valid_in, rd_data_in  controller read return
//   rd_orphan_err            sticky: a return arrived with no outstanding tag
module ddr_req_arbiter #(
  parameter int ADDR_WIDTH         = 13,
  parameter int BANK_WIDTH         = 2,
  parameter int DATA_WIDTH         = 16,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  input  logic                  m1_valid,
  output logic                  m0_ready,
  output logic                  m1_ready,
  input  logic                  m0_we,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [BANK_WIDTH-1:0] m0_bank,
  input  logic [BANK_WIDTH-1:0] m1_bank,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  write_req,
  output logic                  read_req,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [BANK_WIDTH-1:0] bank_out,
  output logic [DATA_WIDTH-1:0] wdata_out,
  input  logic                  ctrl_ready,
  input  logic                  rd_valid_in,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  output logic                  rd_orphan_err
);

  localparam int PTR_W = (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q;
  logic                  is_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BANK_WIDTH-1:0] bank_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  tag_mem_q [MAX_RD_OUTSTANDING];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;

  logic                  m0_rvalid_q, m1_rvalid_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic                  orphan_q;

  logic fifo_full, fifo_empty;
  logic elig0, elig1, can_grant, gnt0, gnt1, grant, gnt_we;
  logic push, pop, head_tag;

  assign fifo_full  = (count_q == CNT_W'(MAX_RD_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // A read is only eligible while a tag slot is free, so the FIFO never overflows.
  assign elig0 = m0_valid & (m0_we | ~fifo_full);
  assign elig1 = m1_valid & (m1_we | ~fifo_full);

  // rst gates ready so neither master sees an acceptance while reset is held.
  assign can_grant = (state_q == IDLE) & ctrl_ready & ~rst;

  // m1 wins only if alone, or if both contend and m0 was granted last.
  assign gnt1   = can_grant & elig1 & (~elig0 | ~last_grant_q);
  assign gnt0   = can_grant & elig0 & ~gnt1;
  assign grant  = gnt0 | gnt1;
  assign gnt_we = gnt1 ? m1_we : m0_we;

  assign push     = grant & ~gnt_we;
  assign pop      = rd_valid_in & ~fifo_empty;
  assign head_tag = tag_mem_q[head_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      bank_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_grant_q <= gnt1;
        is_wr_q      <= gnt_we;
        addr_q       <= gnt1 ? m1_addr  : m0_addr;
        bank_q       <= gnt1 ? m1_bank  : m0_bank;
        wdata_q      <= gnt1 ? m1_wdata : m0_wdata;
      end
    end
  end

  // Tag FIFO: one bit per outstanding read holding the issuing master id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_RD_OUTSTANDING; i++) tag_mem_q[i] <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tag_mem_q[tail_q] <= gnt1;
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (pop) head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Read return routing; the non-addressed master's rdata keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      orphan_q    <= 1'b0;
    end else begin
      m0_rvalid_q <= pop & ~head_tag;
      m1_rvalid_q <= pop & head_tag;
      if (pop & ~head_tag) m0_rdata_q <= rd_data_in;
      if (pop & head_tag)  m1_rdata_q <= rd_data_in;
      if (rd_valid_in & fifo_empty) orphan_q <= 1'b1;
    end
  end

  assign m0_ready      = gnt0;
  assign m1_ready      = gnt1;
  assign write_req     = (state_q == ISSUE) & is_wr_q;
  assign read_req      = (state_q == ISSUE) & ~is_wr_q;
  assign addr_out      = addr_q;
  assign bank_out      = bank_q;
  assign wdata_out     = wdata_q;
  assign m0_rvalid     = m0_rvalid_q;
  assign m1_rvalid     = m1_rvalid_q;
  assign m0_rdata      = m0_rdata_q;
  assign m1_rdata      = m1_rdata_q;
  assign rd_orphan_err = orphan_q;

endmodule

// File: doc/ddr_req_arbiter.md
# ddr_req_arbiter

Two-master request arbiter that sits directly upstream of the DDR memory controller. It accepts valid/ready requests from two masters and converts them into the controller's single-cycle `write_req`/`read_req` pulse interface, pacing issue against `wr_ready`. It also tracks outstanding reads in issue order so each `rd_valid` return goes back to the master that requested it.

## Interface
Parameters:
- `ADDR_WIDTH`, 13: request address width; matches the controller.
- `BANK_WIDTH`, 2: bank select width.
- `DATA_WIDTH`, 16: data width.
- `MAX_RD_OUTSTANDING`, 4: depth of the read-tag FIFO; must be a power of two, at least 2.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `m0_valid`, `m1_valid`  in  1: master request valid.
- `m0_ready`, `m1_ready`  out  1: request accepted this cycle (combinational).
- `m0_we`, `m1_we`  in  1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH: request address.
- `m0_bank`, `m1_bank`  in  BANK_WIDTH: request bank.
- `m0_wdata`, `m1_wdata`  in  DATA_WIDTH: write data.
- `m0_rvalid`, `m1_rvalid`  out  1: read data valid, one-cycle pulse.
- `m0_rdata`, `m1_rdata`  out  DATA_WIDTH: read data.
- `write_req`, `read_req`  out  1: one-cycle pulses to the controller.
- `addr_out`  out  ADDR_WIDTH: address to the controller.
- `bank_out`  out  BANK_WIDTH: bank to the controller.
- `wdata_out`  out  DATA_WIDTH: write data to the controller.
- `ctrl_ready`  in  1: the controller's `wr_ready`.
- `rd_valid_in`  in  1: the controller's `rd_valid`.
- `rd_data_in`  in  DATA_WIDTH: the controller's `rd_data_out`.
- `rd_orphan_err`  out  1: sticky error; a read return arrived with no outstanding tag.

## Operation
- **FSM states:** IDLE, ISSUE, GAP.
  - IDLE→ISSUE on a grant.
  - ISSUE→GAP unconditionally.
  - GAP→IDLE unconditionally.
  - Grants are made only in IDLE.
- **Eligibility:** master X is eligible when `mX_valid` is 1 and either `mX_we`=1, or `mX_we`=0 with the tag FIFO not full.
- **Grant condition:** state is IDLE, `ctrl_ready`=1, and at least one master is eligible.
- **Round-robin:** register `last_grant` resets to 1, so m0 wins the first contention.
  - If both masters are eligible, grant the one that is not `last_grant`.
  - If only one is eligible, grant it.
  - Update `last_grant` on every grant.
- **Grant cycle:**
  - Assert `mX_ready` for the granted master only.
  - Capture its addr, bank and wdata into `addr_out`, `bank_out`, `wdata_out`.
  - Latch the request type.
  - For a read, push the master id into the tag FIFO.
- **ISSUE:** pulse `write_req` or `read_req` high for exactly one cycle; never both.
- **Output hold:** `addr_out`, `bank_out` and `wdata_out` hold their values until the next grant.
- **Read return:**
  - `rd_valid_in`=1 with the tag FIFO non-empty: pop the head tag, then next cycle drive `m<tag>_rvalid`=1 and `m<tag>_rdata`=`rd_data_in`. The other master's rvalid stays 0.
  - `rd_valid_in`=1 with the tag FIFO empty: drop the data and set `rd_orphan_err`. It stays set until reset.
- **Tag FIFO:** head and tail pointers wrap modulo `MAX_RD_OUTSTANDING`, with a count from 0 to `MAX_RD_OUTSTANDING`.
  - A push and pop in the same cycle are both performed; count is unchanged.
  - A push is never attempted when count = `MAX_RD_OUTSTANDING`; eligibility blocks it.
  - A pop on empty is blocked as described above.
- **Non-granted master:** `mX_ready`=0; its request must stay stable until accepted.
- **Reset:** assertion in any state returns the FSM to IDLE. In-flight tags are discarded; returns arriving after reset are treated as orphans.

## Timing
- **Reset values:**
  - `write_req`, `read_req`, `m0_rvalid`, `m1_rvalid`, `rd_orphan_err` = 0.
  - `addr_out`, `bank_out`, `wdata_out`, `m0_rdata`, `m1_rdata` = 0.
  - `m0_ready`, `m1_ready` = 0 while `rst` is high.
  - Tag count = 0; `last_grant` = 1.
- **Issue latency:** grant in cycle T gives the request pulse in cycle T+1.
- **Throughput:** the next grant is possible no earlier than T+3, so at most one request per 3 cycles. The GAP cycle covers the controller's registered `wr_ready` lag.
- **Ready dependence:** `mX_ready` depends combinationally on `mX_valid`, `mX_we`, `ctrl_ready`, FSM state, `last_grant` and tag count. It has no dependence on `rd_valid_in`.
- **Return latency:** `rd_valid_in` in cycle T gives `mX_rvalid` in cycle T+1.
- **Back-to-back returns:** returns on consecutive cycles are each routed; no bubble is inserted.
- **ctrl_ready low:** while `ctrl_ready`=0 in IDLE, no grant is made; state holds IDLE and pending requests wait.

## Test plan
- **Reset values:** hold `rst`=1, then release → all outputs 0, and the first grant goes to m0 when both masters are valid.
- **Single write:** m0 write, addr 0x01A, bank 2, data 0xBEEF → `m0_ready` in cycle T, `write_req`=1 with matching `addr_out`/`bank_out`/`wdata_out` in T+1, no pulse in T+2.
- **Contention:** both masters issue continuous reads → grants alternate m0, m1, m0, m1, 3 cycles apart. Returns with data 0x1111, 0x2222, 0x3333, 0x4444 are routed to m0, m1, m0, m1 respectively.
- **Tag FIFO full:** 4 m1 reads issued with no return → a 5th m1 read stalls (`m1_ready`=0) while an m0 write is still granted. One `rd_valid_in` releases the stall.
- **Orphan and simultaneous push/pop:**
  - `rd_valid_in` pulsed with 0 outstanding → `rd_orphan_err`=1, both rvalids stay 0.
  - Read grant and `rd_valid_in` in the same cycle → count unchanged, correct routing.
- **Reset mid-operation:** assert `rst` in the ISSUE state with 2 reads outstanding → `read_req` goes to 0 immediately, count = 0, and later returns set `rd_orphan_err`.
